// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute stage.
// Holds the alucont operation codes, the status-flag bit positions inside
// the 5-bit {C,L,F,Z,N} flag word, and the output buffer depth.
package alu_pkg;

  // alucont operation codes produced by the decoder
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_COMP = 3'b101;
  localparam logic [2:0] ALU_MOV  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  // Flag word layout {C,L,F,Z,N}
  localparam int unsigned NUM_FLAGS = 5;
  localparam int unsigned FLAG_C    = 4;
  localparam int unsigned FLAG_L    = 3;
  localparam int unsigned FLAG_F    = 2;
  localparam int unsigned FLAG_Z    = 1;
  localparam int unsigned FLAG_N    = 0;

  // Result buffer depth between execute and writeback
  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, writeback enable, next flag values and
// a mask of which flags the operation writes.
// Optional build macro ALU_LSH_EN turns alucont 111 into a logical shift of
// a by the signed amount b[4:0]; otherwise 111 yields result 0, no writeback.
// Ports:
//   alucont_i     operation code
//   a_i, b_i      operands (Rdest, Rsrc/immediate)
//   result_c      operation result
//   wr_en_c       result should be written back
//   flags_c       new values for the flags selected by flags_mask_c
//   flags_mask_c  1 = flag written by this op, 0 = flag left unchanged
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]           alucont_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     result_c,
  output logic                 wr_en_c,
  output logic [NUM_FLAGS-1:0] flags_c,
  output logic [NUM_FLAGS-1:0] flags_mask_c
);

  localparam int unsigned MSB = WIDTH - 1;

  // Extra top bit holds carry (add) or borrow (sub)
  logic [WIDTH:0] sum_c;
  logic [WIDTH:0] diff_c;

  assign sum_c  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_c = {1'b0, a_i} - {1'b0, b_i};

`ifdef ALU_LSH_EN
  // Signed 5-bit shift amount; magnitude of -16 still fits in 5 bits
  logic [4:0]       shamt_mag_c;
  logic [WIDTH-1:0] shift_c;

  always_comb begin
    shamt_mag_c = b_i[4] ? 5'(-b_i[4:0]) : b_i[4:0];
    shift_c     = '0;
    if (32'(shamt_mag_c) < WIDTH) begin
      shift_c = b_i[4] ? (a_i >> shamt_mag_c) : (a_i << shamt_mag_c);
    end
  end
`endif

  // Operation decode
  always_comb begin
    result_c     = '0;
    wr_en_c      = 1'b0;
    flags_c      = '0;
    flags_mask_c = '0;
    case (alucont_i)
      ALU_ADD: begin
        result_c             = sum_c[MSB:0];
        wr_en_c              = 1'b1;
        flags_c[FLAG_C]      = sum_c[WIDTH];
        flags_c[FLAG_F]      = (a_i[MSB] == b_i[MSB]) && (sum_c[MSB] != a_i[MSB]);
        flags_mask_c[FLAG_C] = 1'b1;
        flags_mask_c[FLAG_F] = 1'b1;
      end
      ALU_SUB: begin
        result_c             = diff_c[MSB:0];
        wr_en_c              = 1'b1;
        flags_c[FLAG_C]      = diff_c[WIDTH];
        flags_c[FLAG_F]      = (a_i[MSB] != b_i[MSB]) && (diff_c[MSB] != a_i[MSB]);
        flags_mask_c[FLAG_C] = 1'b1;
        flags_mask_c[FLAG_F] = 1'b1;
      end
      ALU_AND: begin
        result_c = a_i & b_i;
        wr_en_c  = 1'b1;
      end
      ALU_XOR: begin
        result_c = a_i ^ b_i;
        wr_en_c  = 1'b1;
      end
      ALU_OR: begin
        result_c = a_i | b_i;
        wr_en_c  = 1'b1;
      end
      ALU_COMP: begin
        result_c             = a_i;
        flags_c[FLAG_Z]      = (a_i == b_i);
        flags_c[FLAG_L]      = (b_i > a_i);
        flags_c[FLAG_N]      = ($signed(b_i) > $signed(a_i));
        flags_mask_c[FLAG_Z] = 1'b1;
        flags_mask_c[FLAG_L] = 1'b1;
        flags_mask_c[FLAG_N] = 1'b1;
      end
      ALU_MOV: begin
        result_c = b_i;
        wr_en_c  = 1'b1;
      end
      ALU_RSVD: begin
`ifdef ALU_LSH_EN
        result_c = shift_c;
        wr_en_c  = 1'b1;
`else
        result_c = '0;
        wr_en_c  = 1'b0;
`endif
      end
      default: begin
        result_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: accepts operations over valid/ready, computes result and
// status flags, and queues {result, tag, wr_en} in a 2-entry FIFO for
// writeback. Flags are committed on the accepting edge.
// Optional build macro ALU_LSH_EN (see alu_core) enables the shift op on 111.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    operation handshake (in_ready = count < 2)
//   alucont, a, b        operation code and operands
//   tag_in               destination register index
//   out_valid/out_ready  head-of-buffer handshake to writeback
//   result, tag_out      head entry payload
//   wr_en                head entry should be written to the register file
//   flags                {C,L,F,Z,N} status register
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAGW  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           alucont,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [TAGW-1:0]      tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [TAGW-1:0]      tag_out,
  output logic                 wr_en,
  output logic [NUM_FLAGS-1:0] flags
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(BUF_DEPTH);

  // Entry 0 is always the head; a pop shifts the younger entry down
  logic [WIDTH-1:0]     res_q [BUF_DEPTH];
  logic [WIDTH-1:0]     res_d [BUF_DEPTH];
  logic [TAGW-1:0]      tag_q [BUF_DEPTH];
  logic [TAGW-1:0]      tag_d [BUF_DEPTH];
  logic                 wr_q  [BUF_DEPTH];
  logic                 wr_d  [BUF_DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;

  logic [WIDTH-1:0]     core_res_c;
  logic                 core_wr_c;
  logic [NUM_FLAGS-1:0] core_flags_c;
  logic [NUM_FLAGS-1:0] core_mask_c;
  logic                 push_c, pop_c;
  logic [IDX_W-1:0]     slot_c;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .alucont_i    (alucont),
    .a_i          (a),
    .b_i          (b),
    .result_c     (core_res_c),
    .wr_en_c      (core_wr_c),
    .flags_c      (core_flags_c),
    .flags_mask_c (core_mask_c)
  );

  assign in_ready  = (count_q < CNT_W'(BUF_DEPTH));
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  assign result  = res_q[0];
  assign tag_out = tag_q[0];
  assign wr_en   = wr_q[0];
  assign flags   = flags_q;

  // Next-state for FIFO, count and flags
  always_comb begin
    res_d   = res_q;
    tag_d   = tag_q;
    wr_d    = wr_q;
    count_d = count_q;
    flags_d = flags_q;
    slot_c  = '0;

    if (pop_c) begin
      for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
        res_d[i] = res_q[i+1];
        tag_d[i] = tag_q[i+1];
        wr_d[i]  = wr_q[i+1];
      end
    end

    if (push_c) begin
      // Write lands behind whatever survives this cycle's pop
      slot_c        = IDX_W'(count_q - CNT_W'(pop_c));
      res_d[slot_c] = core_res_c;
      tag_d[slot_c] = tag_in;
      wr_d[slot_c]  = core_wr_c;
      flags_d       = (flags_q & ~core_mask_c) | (core_flags_c & core_mask_c);
    end

    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
        wr_q[i]  <= 1'b0;
      end
      count_q <= '0;
      flags_q <= '0;
    end else begin
      res_q   <= res_d;
      tag_q   <= tag_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

endmodule
